// File: rtl/pipe_pkg.sv
// Purpose: shared stage indices and pipeline-control types for the in-order MIPS core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    // Default stage numbering of the classic 5-stage pipe
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam int DEF_NUM_STAGES = 5;
    localparam int DEF_RADDR_W    = 5;
    localparam int DEF_SEL_W      = $clog2(DEF_NUM_STAGES);

    // Forwarding select: producer stage index, 0 = register file
    typedef logic [DEF_SEL_W-1:0] stage_sel_t;

    // Per-stage occupancy plus destination scoreboard entry
    typedef struct packed {
        logic                   valid;
        logic                   we;
        logic                   is_load;
        logic [DEF_RADDR_W-1:0] dest;
    } stage_meta_t;

endpackage

// File: rtl/pipe_fwd_match.sv
// Purpose: youngest-producer search for one decode source over stages DEC+1..last.
// Latency: combinational.
// Backpressure: none; reports whether the winning producer is a load whose data is not yet forwardable.
module pipe_fwd_match
    import pipe_pkg::*;
#(
    parameter int NC               = 3,
    parameter int BASE             = STG_EX,
    parameter int LOAD_READY_STAGE = STG_WB,
    parameter int RADDR_W          = 5,
    parameter int SEL_W            = 3
) (
    input  logic [RADDR_W-1:0]    src,
    input  logic                  src_used,
    input  logic [NC-1:0]         cand_vld,
    input  logic [NC-1:0]         cand_we,
    input  logic [NC-1:0]         cand_ld,
    input  logic [NC*RADDR_W-1:0] cand_dest,
    output logic [SEL_W-1:0]      sel,
    output logic                  not_ready
);

    // Scan oldest to youngest so the youngest matching producer overwrites the rest
    always_comb begin
        sel       = '0;
        not_ready = 1'b0;
        for (int i = NC - 1; i >= 0; i--) begin
            if (cand_vld[i] && cand_we[i] && src_used && (src != '0) &&
                (cand_dest[i*RADDR_W +: RADDR_W] == src)) begin
                sel       = SEL_W'(BASE + i);
                not_ready = cand_ld[i] && ((BASE + i) < LOAD_READY_STAGE);
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Purpose: per-stage valid/scoreboard, advance/flush enables, forwarding selects, load-use stall.
//          Optional perf counters when PIPE_CTRL_PERF_EN is defined.
// Latency: enables/selects combinational from state; valid/scoreboard update on the next clock.
// Backpressure: a stalled stage holds itself and every valid stage behind it; bubbles collapse.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int NUM_STAGES       = DEF_NUM_STAGES,
    parameter int DEC_STAGE        = STG_ID,
    parameter int REDIRECT_STAGE   = STG_MEM,
    parameter int LOAD_READY_STAGE = STG_WB,
    parameter int RADDR_W          = DEF_RADDR_W,
    parameter int SEL_W            = $clog2(NUM_STAGES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [NUM_STAGES-1:0] stage_stall_req,
    input  logic [RADDR_W-1:0]    dec_dest,
    input  logic                  dec_we,
    input  logic                  dec_is_load,
    input  logic [RADDR_W-1:0]    dec_src0,
    input  logic [RADDR_W-1:0]    dec_src1,
    input  logic                  dec_src0_used,
    input  logic                  dec_src1_used,
    input  logic                  redirect,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic [NUM_STAGES-1:0] stage_advance,
    output logic [NUM_STAGES-1:0] stage_flush,
    output logic [SEL_W-1:0]      fwd_sel0,
    output logic [SEL_W-1:0]      fwd_sel1,
    output logic                  hazard_stall
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_count
`endif
);

    localparam int FIRST_META = DEC_STAGE + 1;
    localparam int NC         = NUM_STAGES - FIRST_META;

    typedef struct packed {
        logic               we;
        logic               is_load;
        logic [RADDR_W-1:0] dest;
    } meta_t;

    logic [NUM_STAGES-1:1] valid_q, valid_d;
    meta_t                 meta_q [FIRST_META:NUM_STAGES-1];
    meta_t                 meta_d [FIRST_META:NUM_STAGES-1];

    logic [NUM_STAGES-1:0] valid;
    logic [NUM_STAGES:0]   hold;
    logic [NUM_STAGES-1:0] squash;
    logic                  redir_take;
    logic                  hazard;
    logic                  hazard_raw;

    logic [NC-1:0]         cand_vld, cand_we, cand_ld;
    logic [NC*RADDR_W-1:0] cand_dest;
    logic [SEL_W-1:0]      sel0, sel1;
    logic                  nr0, nr1;

    // Fetch occupancy comes straight from the issue handshake; the rest is registered
    always_comb begin
        valid = {valid_q, issue_valid};
    end

    // Flatten the scoreboard of the producer stages for the match units
    always_comb begin
        cand_vld  = '0;
        cand_we   = '0;
        cand_ld   = '0;
        cand_dest = '0;
        for (int i = 0; i < NC; i++) begin
            cand_vld[i]                      = valid[FIRST_META + i];
            cand_we[i]                       = meta_q[FIRST_META + i].we;
            cand_ld[i]                       = meta_q[FIRST_META + i].is_load;
            cand_dest[i*RADDR_W +: RADDR_W]  = meta_q[FIRST_META + i].dest;
        end
    end

    pipe_fwd_match #(
        .NC(NC), .BASE(FIRST_META), .LOAD_READY_STAGE(LOAD_READY_STAGE),
        .RADDR_W(RADDR_W), .SEL_W(SEL_W)
    ) u_match0 (
        .src(dec_src0), .src_used(dec_src0_used),
        .cand_vld(cand_vld), .cand_we(cand_we), .cand_ld(cand_ld), .cand_dest(cand_dest),
        .sel(sel0), .not_ready(nr0)
    );

    pipe_fwd_match #(
        .NC(NC), .BASE(FIRST_META), .LOAD_READY_STAGE(LOAD_READY_STAGE),
        .RADDR_W(RADDR_W), .SEL_W(SEL_W)
    ) u_match1 (
        .src(dec_src1), .src_used(dec_src1_used),
        .cand_vld(cand_vld), .cand_we(cand_we), .cand_ld(cand_ld), .cand_dest(cand_dest),
        .sel(sel1), .not_ready(nr1)
    );

    // Hold chain from writeback backward; the redirect decision is taken when the
    // walk passes the redirect stage (downstream of decode), so it can veto the
    // load-use stall before decode's hold is evaluated.
    always_comb begin
        hold       = '0;
        redir_take = 1'b0;
        hazard     = 1'b0;
        hazard_raw = valid[DEC_STAGE] & (nr0 | nr1);
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (k == DEC_STAGE) begin
                hazard = hazard_raw & ~redir_take;
            end
            hold[k] = valid[k] & (stage_stall_req[k] | hold[k+1] | ((k == DEC_STAGE) & hazard));
            if (k == REDIRECT_STAGE) begin
                redir_take = redirect & valid[k] & ~hold[k];
            end
        end
    end

    // Everything younger than an honoured redirect is squashed
    always_comb begin
        squash = '0;
        for (int k = 0; k < REDIRECT_STAGE; k++) begin
            squash[k] = redir_take;
        end
    end

    // Next valid bits and scoreboard: held stages keep contents unless squashed
    always_comb begin
        valid_d = valid_q;
        for (int k = FIRST_META; k < NUM_STAGES; k++) begin
            meta_d[k] = meta_q[k];
        end
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (squash[k]) begin
                valid_d[k] = 1'b0;
            end else if (!hold[k]) begin
                valid_d[k] = stage_advance[k-1] & ~squash[k-1];
            end
        end
        if (!hold[FIRST_META]) begin
            meta_d[FIRST_META] = '{we: dec_we, is_load: dec_is_load, dest: dec_dest};
        end
        for (int k = FIRST_META + 1; k < NUM_STAGES; k++) begin
            if (!hold[k]) begin
                meta_d[k] = meta_q[k-1];
            end
        end
    end

    // Pipeline state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = FIRST_META; k < NUM_STAGES; k++) begin
                meta_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = FIRST_META; k < NUM_STAGES; k++) begin
                meta_q[k] <= meta_d[k];
            end
        end
    end

    // Control outputs
    always_comb begin
        stage_valid   = valid;
        stage_advance = valid & ~hold[NUM_STAGES-1:0];
        stage_flush   = squash;
        fwd_sel0      = sel0;
        fwd_sel1      = sel1;
        hazard_stall  = hazard;
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Saturating event counters: decode-hold cycles and honoured redirects
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (hold[DEC_STAGE] && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (redir_take && (perf_flush_q != '1)) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_count  = perf_flush_q;
`endif

endmodule
